// File: rtl/mem_access_ctrl.sv
// Memory access controller: accepts one CPU read/write request at a time,
// runs a four-phase handshake (EN / MFC) against an asynchronous memory and
// reports completion or timeout with a single-cycle done pulse.
module mem_access_ctrl #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        req_rw,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [15:0] rdata,
   output logic [15:0] MAR_to_MEM,
   output logic [15:0] MDR_to_MEM,
   output logic        EN,
   output logic        RW,
   input  logic        MFC,
   input  logic [15:0] MEM_to_MDR
);

   localparam int CW = $clog2(TIMEOUT + 1);

   // One-hot so every output is a single state flop (glitch-free strobe).
   typedef enum logic [5:0] {
      IDLE    = 6'b000001,
      SETUP   = 6'b000010,
      STROBE  = 6'b000100,
      RELEASE = 6'b001000,
      DONE    = 6'b010000,
      ERR     = 6'b100000
   } state_t;

   state_t          r_state, w_next;
   logic            r_sync1, r_sync2;
   logic [CW-1:0]   r_wait;
   logic [15:0]     r_mar, r_mdr, r_rdata;
   logic            r_rw;
   logic            w_mfc_s, w_tmo, w_accept, w_capture, w_waiting;

   assign w_mfc_s   = r_sync2;
   assign w_tmo     = (r_wait == CW'(TIMEOUT - 1));
   assign w_waiting = r_state[1] | r_state[2] | r_state[3];

   // Two-flop synchronizer for the asynchronous MFC handshake input.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= MFC;
         r_sync2 <= r_sync1;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // Next-state decode; accept and read-capture strobes fall out of it.
   always_comb begin
      w_next    = r_state;
      w_accept  = 1'b0;
      w_capture = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (req) begin
               w_next   = SETUP;
               w_accept = 1'b1;
            end
         end
         SETUP: begin
            // Wait for any leftover MFC from a previous access to clear.
            if (!w_mfc_s)   w_next = STROBE;
            else if (w_tmo) w_next = ERR;
         end
         STROBE: begin
            if (w_mfc_s) begin
               w_next    = RELEASE;
               w_capture = r_rw;
            end else if (w_tmo) begin
               w_next = ERR;
            end
         end
         RELEASE: begin
            if (!w_mfc_s)   w_next = DONE;
            else if (w_tmo) w_next = ERR;
         end
         DONE:    w_next = IDLE;
         ERR:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Per-state wait counter; restarts on every state change.
   always_ff @(posedge clk) begin
      if (reset)                  r_wait <= '0;
      else if (w_next != r_state) r_wait <= '0;
      else if (w_waiting)         r_wait <= r_wait + 1'b1;
   end

   // Access registers: address/data/direction held for the whole access.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mar   <= '0;
         r_mdr   <= '0;
         r_rw    <= 1'b1;
         r_rdata <= '0;
      end else begin
         if (w_accept) begin
            r_mar <= req_addr;
            r_mdr <= req_wdata;
            r_rw  <= req_rw;
         end
         if (w_capture) r_rdata <= MEM_to_MDR;
      end
   end

   assign EN         = r_state[2];
   assign busy       = ~r_state[0];
   assign done       = r_state[4] | r_state[5];
   assign err        = r_state[5];
   assign rdata      = r_rdata;
   assign MAR_to_MEM = r_mar;
   assign MDR_to_MEM = r_mdr;
   assign RW         = r_rw;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioral asynchronous memory:
// MFC rises 5 ns after EN rises and falls when EN falls.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        reset, req, req_rw;
   logic [15:0] req_addr, req_wdata;
   logic        busy, done, err, EN, RW, MFC;
   logic [15:0] rdata, MAR_to_MEM, MDR_to_MEM, MEM_to_MDR;

   logic        mfc_mem = 1'b0;
   logic        mfc_force = 1'b0;
   logic        mem_mute = 1'b0;
   logic [15:0] mem [0:255];

   int checks = 0;
   int errors = 0;

   mem_access_ctrl #(.TIMEOUT(15)) dut (
      .clk(clk), .reset(reset), .req(req), .req_rw(req_rw),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .busy(busy), .done(done), .err(err), .rdata(rdata),
      .MAR_to_MEM(MAR_to_MEM), .MDR_to_MEM(MDR_to_MEM),
      .EN(EN), .RW(RW), .MFC(MFC), .MEM_to_MDR(MEM_to_MDR)
   );

   always #5 clk = ~clk;

   // Memory model
   assign MFC        = mfc_mem | mfc_force;
   assign MEM_to_MDR = mfc_mem ? mem[MAR_to_MEM[7:0]] : 16'hDEAD;

   always @(posedge EN) begin
      #5;
      if (EN === 1'b1 && !mem_mute) begin
         mfc_mem = 1'b1;
         if (RW === 1'b0) mem[MAR_to_MEM[7:0]] = MDR_to_MEM;
      end
   end

   always @(negedge EN) mfc_mem = 1'b0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one request for a single edge, then observes until two cycles
   // after the done pulse (bounded). Cycle 1 is the cycle after accept.
   task automatic do_access(input logic rw, input logic [15:0] addr, input logic [15:0] wdata,
                            output int en_first, output int en_cnt,
                            output int done_cyc, output int done_cnt,
                            output logic err_d, output logic [15:0] mar_d,
                            output logic [15:0] mdr_d, output logic rw_d);
      req = 1'b1; req_rw = rw; req_addr = addr; req_wdata = wdata;
      tick();
      req = 1'b0;
      en_first = -1; en_cnt = 0; done_cyc = -1; done_cnt = 0;
      err_d = 1'bx; mar_d = 'x; mdr_d = 'x; rw_d = 1'bx;
      for (int c = 1; c <= 60; c++) begin
         if (EN === 1'b1) begin
            if (en_first < 0) en_first = c;
            en_cnt++;
         end
         if (done === 1'b1) begin
            done_cnt++;
            if (done_cyc < 0) begin
               done_cyc = c; err_d = err; mar_d = MAR_to_MEM;
               mdr_d = MDR_to_MEM; rw_d = RW;
            end
         end
         if (done_cyc > 0 && c >= done_cyc + 2) break;
         tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; req = 1'b0; req_rw = 1'b0; req_addr = '0; req_wdata = '0;
      tick(); tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (EN !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", EN); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
      checks++; if (rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0000", rdata); end
      checks++; if (MAR_to_MEM !== 16'h0) begin errors++; $display("FAIL reset_mar: got %h want 0000", MAR_to_MEM); end
      checks++; if (MDR_to_MEM !== 16'h0) begin errors++; $display("FAIL reset_mdr: got %h want 0000", MDR_to_MEM); end
      checks++; if (RW !== 1'b1) begin errors++; $display("FAIL reset_rw: got %b want 1", RW); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_read_timing();
      logic [15:0] en_v, done_v;
      logic        err_any, busy1;
      en_v = '0; done_v = '0; err_any = 1'b0; busy1 = 1'b0;
      req = 1'b1; req_rw = 1'b1; req_addr = 16'h0001; req_wdata = 16'h0;
      tick();
      req = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         en_v[c]   = EN;
         done_v[c] = done;
         if (err === 1'b1) err_any = 1'b1;
         if (c == 1) busy1 = busy;
         if (c < 10) tick();
      end
      checks++; if (en_v !== 16'h001C) begin errors++; $display("FAIL read_en_cycles: got %h want 001c", en_v); end
      checks++; if (done_v !== 16'h0100) begin errors++; $display("FAIL read_done_cycle: got %h want 0100", done_v); end
      checks++; if (rdata !== 16'hF0AF) begin errors++; $display("FAIL read_rdata: got %h want f0af", rdata); end
      checks++; if (err_any !== 1'b0) begin errors++; $display("FAIL read_err: got %b want 0", err_any); end
      checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL read_busy_after_accept: got %b want 1", busy1); end
   endtask

   task automatic test_write_readback();
      int ef, ec, dc, dn; logic e, r; logic [15:0] ma, md;
      do_access(1'b0, 16'h0040, 16'h1234, ef, ec, dc, dn, e, ma, md, r);
      checks++; if (dc !== 8) begin errors++; $display("FAIL write_done_cycle: got %0d want 8", dc); end
      checks++; if (rdata !== 16'hF0AF) begin errors++; $display("FAIL write_rdata_kept: got %h want f0af", rdata); end
      checks++; if ({r, ma, md} !== {1'b0, 16'h0040, 16'h1234}) begin
         errors++; $display("FAIL write_bus: got rw=%b mar=%h mdr=%h want rw=0 mar=0040 mdr=1234", r, ma, md); end
      do_access(1'b1, 16'h0040, 16'h0000, ef, ec, dc, dn, e, ma, md, r);
      checks++; if (rdata !== 16'h1234) begin errors++; $display("FAIL readback_rdata: got %h want 1234", rdata); end
      checks++; if ({dc, dn, e} !== {32'sd8, 32'sd1, 1'b0}) begin
         errors++; $display("FAIL readback_done: got cyc=%0d cnt=%0d err=%b want 8/1/0", dc, dn, e); end
   endtask

   task automatic test_timeout();
      int ef, ec, dc, dn; logic e, r; logic [15:0] ma, md;
      mem_mute = 1'b1;
      do_access(1'b1, 16'h0022, 16'h0000, ef, ec, dc, dn, e, ma, md, r);
      mem_mute = 1'b0;
      checks++; if (ef !== 2) begin errors++; $display("FAIL tmo_en_first: got %0d want 2", ef); end
      checks++; if (ec !== 15) begin errors++; $display("FAIL tmo_en_count: got %0d want 15", ec); end
      checks++; if (dc !== 17) begin errors++; $display("FAIL tmo_err_cycle: got %0d want 17", dc); end
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL tmo_err_flag: got %b want 1", e); end
      checks++; if (rdata !== 16'h1234) begin errors++; $display("FAIL tmo_rdata_kept: got %h want 1234", rdata); end
      checks++; if (ma !== 16'h0022) begin errors++; $display("FAIL tmo_mar_stable: got %h want 0022", ma); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_idle_after: got %b want 0", busy); end
   endtask

   task automatic test_stale_mfc();
      int ef, ec, dc, dn; logic e, r; logic [15:0] ma, md;
      mfc_force = 1'b1;
      tick(); tick();
      fork
         do_access(1'b1, 16'h0022, 16'h0000, ef, ec, dc, dn, e, ma, md, r);
         begin
            repeat (3) @(posedge clk);
            #2 mfc_force = 1'b0;
         end
      join
      checks++; if (ef !== 6) begin errors++; $display("FAIL stale_en_first: got %0d want 6", ef); end
      checks++; if (ec !== 3) begin errors++; $display("FAIL stale_en_count: got %0d want 3", ec); end
      checks++; if (dc !== 12) begin errors++; $display("FAIL stale_done_cycle: got %0d want 12", dc); end
      checks++; if (rdata !== 16'hBEEF) begin errors++; $display("FAIL stale_rdata: got %h want beef", rdata); end
   endtask

   task automatic test_reset_mid();
      int ef, ec, dc, dn; logic e, r; logic [15:0] ma, md; logic en_pre;
      req = 1'b1; req_rw = 1'b1; req_addr = 16'h0040; req_wdata = 16'h0;
      tick();
      req = 1'b0;
      tick(); tick();
      en_pre = EN;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (en_pre !== 1'b1) begin errors++; $display("FAIL rstmid_in_strobe: got %b want 1", en_pre); end
      checks++; if ({EN, busy} !== 2'b00) begin errors++; $display("FAIL rstmid_en_busy: got %b%b want 00", EN, busy); end
      checks++; if (rdata !== 16'h0) begin errors++; $display("FAIL rstmid_rdata: got %h want 0000", rdata); end
      checks++; if ({RW, MAR_to_MEM} !== {1'b1, 16'h0}) begin
         errors++; $display("FAIL rstmid_regs: got rw=%b mar=%h want 1/0000", RW, MAR_to_MEM); end
      tick();
      do_access(1'b1, 16'h0001, 16'h0000, ef, ec, dc, dn, e, ma, md, r);
      checks++; if ({dc, rdata, e} !== {32'sd8, 16'hF0AF, 1'b0}) begin
         errors++; $display("FAIL rstmid_followup: got cyc=%0d rdata=%h err=%b want 8/f0af/0", dc, rdata, e); end
      // reset and req together: reset wins, nothing starts
      reset = 1'b1; req = 1'b1; req_addr = 16'h0022;
      tick();
      reset = 1'b0; req = 1'b0;
      tick();
      checks++; if ({busy, MAR_to_MEM} !== {1'b0, 16'h0}) begin
         errors++; $display("FAIL rst_beats_req: got busy=%b mar=%h want 0/0000", busy, MAR_to_MEM); end
   endtask

   task automatic test_back_to_back();
      logic [23:0] busy_v, done_v, exp_busy;
      logic [15:0] mar5, rd9;
      busy_v = '0; done_v = '0; exp_busy = '0; mar5 = '0; rd9 = '0;
      for (int c = 1; c <= 22; c++) exp_busy[c] = (c <= 8) || (c >= 10 && c <= 17);
      req = 1'b1; req_rw = 1'b1; req_addr = 16'h0022;
      tick();
      for (int c = 1; c <= 22; c++) begin
         busy_v[c] = busy;
         done_v[c] = done;
         if (c == 5) begin mar5 = MAR_to_MEM; req_addr = 16'h0040; end
         if (c == 9) rd9 = rdata;
         if (c == 10) req = 1'b0;
         if (c < 22) tick();
      end
      checks++; if (busy_v !== exp_busy) begin errors++; $display("FAIL b2b_busy: got %h want %h", busy_v, exp_busy); end
      checks++; if (done_v !== 24'h020100) begin errors++; $display("FAIL b2b_done: got %h want 020100", done_v); end
      checks++; if (mar5 !== 16'h0022) begin errors++; $display("FAIL b2b_mar_stable: got %h want 0022", mar5); end
      checks++; if (rd9 !== 16'hBEEF) begin errors++; $display("FAIL b2b_first_rdata: got %h want beef", rd9); end
      checks++; if (rdata !== 16'h1234) begin errors++; $display("FAIL b2b_second_rdata: got %h want 1234", rdata); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[8'h01] = 16'hF0AF;
      mem[8'h22] = 16'hBEEF;
      test_reset();
      test_read_timing();
      test_write_readback();
      test_timeout();
      test_stale_mfc();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (rising edge) and reset (active-high, synchronous); no other clocks or asynchronous resets.
REQ-002 Parameter TIMEOUT, default 15, SHALL be the maximum number of cycles spent waiting on any MFC level before an error is declared.
REQ-003 clk  input  1  system clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 req  input  1  CPU-side access request, sampled only in IDLE.
REQ-006 req_rw  input  1  access type: 1 = read, 0 = write.
REQ-007 req_addr  input  16  access address.
REQ-008 req_wdata  input  16  write data.
REQ-009 busy  output  1  high from the cycle after accept through the DONE/ERR cycle.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 err  output  1  one-cycle timeout flag, coincident with done.
REQ-012 rdata  output  16  last successfully read word.
REQ-013 MAR_to_MEM  output  16  address to memory.
REQ-014 MDR_to_MEM  output  16  write data to memory.
REQ-015 EN  output  1  memory strobe, active high.
REQ-016 RW  output  1  1 = read, 0 = write.
REQ-017 MFC  input  1  memory-function-complete, asynchronous to clk.
REQ-018 MEM_to_MDR  input  16  read data from memory, valid while MFC is high.

Function
REQ-019 MFC SHALL pass through a 2-flop synchronizer (mfc_s); no FSM decision SHALL use raw MFC.
REQ-020 FSM states SHALL be IDLE, SETUP, STROBE, RELEASE, DONE, ERR.
REQ-021 IDLE: busy=0 and EN=0; req=1 at an edge SHALL latch req_addr, req_wdata and req_rw into MAR_to_MEM, MDR_to_MEM and RW, then go to SETUP.
REQ-022 SETUP: EN=0; go to STROBE on the first edge that samples mfc_s=0 (stale-MFC guard).
REQ-023 STROBE: EN=1; on the first edge that samples mfc_s=1, go to RELEASE; on a read, load rdata from MEM_to_MDR at that same edge.
REQ-024 RELEASE: EN=0; go to DONE on the first edge that samples mfc_s=0.
REQ-025 DONE: done=1, busy=1 for exactly one cycle, then go to IDLE.
REQ-026 ERR: done=1, err=1, busy=1, EN=0 for exactly one cycle, then go to IDLE; rdata SHALL be unchanged.
REQ-027 A wait counter SHALL clear on every state change; reaching TIMEOUT cycles in SETUP, STROBE or RELEASE SHALL go to ERR.
REQ-028 MAR_to_MEM, MDR_to_MEM and RW SHALL stay stable from the accept edge until the IDLE return, including across ERR.
REQ-029 req SHALL be ignored while busy; a req held high through DONE SHALL be accepted on the first IDLE edge, so back-to-back accesses have one IDLE cycle between them.
REQ-030 A write SHALL never modify rdata.
REQ-031 EN SHALL be a direct decode of state (STROBE only) and SHALL be glitch-free.

Reset
REQ-032 reset=1 at an edge SHALL force IDLE from any state, including STROBE/RELEASE mid-access, and SHALL clear the following: EN=0, busy=0, done=0, err=0, rdata=0, MAR_to_MEM=0, MDR_to_MEM=0, RW=1, wait counter=0, synchronizer flops=0.
REQ-033 When reset and req are both high at the same edge, reset SHALL win and no access SHALL start.

Verification
REQ-034 Basic read timing: 10 ns clk; memory raises MFC 5 ns after EN rises and drops MFC when EN falls; read req at edge 0 to addr 0x0001 returning 0xF0AF -> EN high during cycles 2-4, done=1 in cycle 8, rdata=0xF0AF, err=0.
REQ-035 Write then read-back: write 0x1234 to 0x0040, then read 0x0040 -> first access completes with rdata unchanged; second access gives rdata=0x1234.
REQ-036 Missing MFC: read req, memory never raises MFC, TIMEOUT=15 -> EN high for 15 cycles; then ERR cycle with done=1, err=1; EN=0; rdata holds its previous value.
REQ-037 Stale MFC: MFC forced high before accept, released after 3 cycles -> EN stays 0 until mfc_s=0 is sampled; the access then completes normally.
REQ-038 Reset mid-access: reset pulsed during STROBE -> EN=0 and busy=0 at the next edge; rdata=0; a following read completes correctly.
REQ-039 Held req: req held high across two accesses -> exactly one IDLE cycle between the DONE of the first and SETUP of the second; each access produces exactly one done pulse.
